text_ram_arbiter: RTL
=====================

TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 SHALL have parameters: DEPTH, default 328, number of 32-bit display-RAM words; AW, default 9, address width; FIFO_DEPTH, default 4, host write queue entries; FILL, default 32'h20202020, clear pattern (four ASCII spaces).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- vid_req  in  1  video fetch request this cycle.
- vid_addr  in  AW  video fetch word address.
- vid_data  out  32  fetched word.
- vid_valid  out  1  vid_data valid.
- host_wr_valid  in  1  host write offered.
- host_wr_ready  out  1  queue can accept.
- host_wr_addr  in  AW  host write word address.
- host_wr_data  in  32  host write data.
- clear_start  in  1  pulse; fill entire RAM with FILL.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse at clear completion.
- addr_err  out  1  sticky; out-of-range host write dropped.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid 1 cycle after the address.

Function
REQ-003 SHALL drive exactly one RAM access per cycle, priority: video read > clear write > queued host write.
REQ-004 Video: on vid_req=1, mem_addr=vid_addr, mem_we=0; vid_valid=1 and vid_data=mem_rdata registered, exactly 2 cycles after vid_req (address cycle + RAM latency + output register); video is never stalled.
REQ-005 vid_addr >= DEPTH SHALL still issue the read, and vid_data SHALL be 0 for that request.
REQ-006 Host queue: FIFO of FIFO_DEPTH {addr,data}; push when host_wr_valid & host_wr_ready; host_wr_ready = !full (registered-count based, no combinational path from host_wr_valid).
REQ-007 Simultaneous push and pop with a non-full FIFO SHALL keep the count unchanged and preserve order; push SHALL NOT occur when full.
REQ-008 Pop SHALL occur only in a cycle with vid_req=0 and state IDLE; a popped entry with addr < DEPTH drives mem_we=1, mem_addr, mem_wdata; addr >= DEPTH performs no write and sets addr_err.
REQ-009 addr_err SHALL remain 1 until reset.
REQ-010 FSM states IDLE, CLEAR. IDLE->CLEAR on clear_start=1 (clear counter := 0). CLEAR->IDLE after the write of address DEPTH-1.
REQ-011 In CLEAR, each cycle with vid_req=0 writes FILL to the counter address and increments it; cycles with vid_req=1 do not advance it.
REQ-012 clear_busy=1 exactly while in CLEAR; clear_done=1 for one cycle, the cycle after the final clear write.
REQ-013 clear_start while in CLEAR SHALL be ignored (no restart).
REQ-014 During CLEAR the host FIFO SHALL still accept pushes up to full but SHALL NOT pop; queued writes drain after CLEAR, so they overwrite FILL.
REQ-015 Counter and address arithmetic SHALL be AW bits, unsigned; no wrap beyond DEPTH-1.

Reset
REQ-016 While rst_n=0 at a clk edge: state IDLE, FIFO empty, clear counter 0, and the outputs vid_data=0, vid_valid=0, clear_busy=0, clear_done=0, addr_err=0, mem_we=0, mem_addr=0, mem_wdata=0; host_wr_ready=1 from the first cycle after reset.
REQ-017 Reset asserted during CLEAR or with a non-empty FIFO SHALL abort the clear and discard queued writes, with no further mem_we.

Verification
REQ-018 Video read: RAM[5]=32'h41424344, vid_req=1, vid_addr=5 at cycle t -> vid_valid=1, vid_data=32'h41424344 at t+2.
REQ-019 Priority: host write addr 10 data 32'hDEADBEEF queued while vid_req held high for 8 cycles -> no mem_we during those 8 cycles; the write occurs in the first cycle vid_req=0.
REQ-020 Backpressure: 5 back-to-back host writes with vid_req=1 constant -> host_wr_ready=0 after the 4th accept; all 4 written in order once vid_req drops; the 5th is accepted after the first pop.
REQ-021 Clear: clear_start with no video -> 328 consecutive mem_we with FILL at addresses 0..327; clear_done pulses at start+329; clear_busy high for 328 cycles; a second clear_start mid-clear has no effect.
REQ-022 Bad address: host write addr 400 -> no mem_we for that entry; addr_err=1 and stays 1 until rst_n=0.
REQ-023 Reset mid-clear at counter 100 -> mem_we=0, clear_busy=0, clear_done=0 the next cycle; FIFO empty, host_wr_ready=1.

Source files
------------

// File: rtl/text_ram_arbiter.sv
// Text-mode display RAM arbiter: one RAM access per cycle shared between video fetch,
// a full-RAM clear engine and a small queue of host writes (priority in that order).
module text_ram_arbiter #(
  parameter int unsigned DEPTH      = 328,
  parameter int unsigned AW         = 9,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] FILL       = 32'h20202020
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [31:0]   vid_data,
  output logic          vid_valid,
  input  logic          host_wr_valid,
  output logic          host_wr_ready,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [31:0]   host_wr_data,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          addr_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } entry_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  entry_t        fifo_mem [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, head_ok, clr_wr;
  logic          vid_pend, vid_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head          = fifo_mem[rd_ptr];
  assign head_ok       = in_range(head.addr);
  // Ready comes only from the registered count, so valid never loops back into ready.
  assign host_wr_ready = (count != FULL_CNT);
  assign push          = host_wr_valid && host_wr_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_start) state_nxt = CLEAR;
      CLEAR:   if (clr_wr && clr_cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR);
    clr_wr     = 1'b0;
    pop        = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (rst_n) begin
      if (vid_req) begin
        mem_addr = vid_addr;
      end else if (state == CLEAR) begin
        clr_wr    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = FILL;
      end else if (count != '0) begin
        // An out-of-range entry is still consumed, it just never reaches the RAM.
        pop = 1'b1;
        if (head_ok) begin
          mem_we    = 1'b1;
          mem_addr  = head.addr;
          mem_wdata = head.data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt    <= '0;
      clear_done <= 1'b0;
      addr_err   <= 1'b0;
      vid_pend   <= 1'b0;
      vid_ok     <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
    end else begin
      if (state == IDLE && clear_start) clr_cnt <= '0;
      else if (clr_wr)                  clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
      clear_done <= clr_wr && (clr_cnt == LAST);
      if (pop && !head_ok) addr_err <= 1'b1;
      // Address cycle, then RAM latency, then this output register.
      vid_pend  <= vid_req;
      vid_ok    <= in_range(vid_addr);
      vid_valid <= vid_pend;
      vid_data  <= (vid_pend && vid_ok) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: queue storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: host_wr_addr, data: host_wr_data};
  end

endmodule
